// File: rtl/fetch.sv
// Instruction fetch stage for the multi-cycle CPU: waits ROM_LAT cycles on the ROM, then holds the fetched word for decode.
// Optional misaligned-fetch trap is enabled by defining FETCH_ALIGN_CHK_EN.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ROM_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IF_valid,
    input  logic        next_fetch,
    input  logic [32:0] jbr_bus,
    input  logic [31:0] inst,
    output logic [31:0] inst_addr,
    output logic        IF_over,
    output logic [63:0] IF_ID_bus,
    output logic [31:0] IF_pc,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // cnt counts the remaining ROM wait cycles; capture happens when it reaches zero
    localparam logic [1:0] CNT_LOAD = 2'(ROM_LAT - 1);

    state_t      state;
    state_t      state_next;
    logic [1:0]  cnt;
    logic [31:0] pc;
    logic [31:0] inst_r;
    logic [31:0] inst_cap;

    logic        capture;
    logic        pc_load;
    logic        cnt_load;
    logic        cnt_dec;
    logic        over_keep;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Dropping IF_valid always returns to IDLE, even if next_fetch is high
    always_comb begin
        state_next = state;
        if (!IF_valid) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = WAIT;
                WAIT:    if (cnt == 2'd0) state_next = DONE;
                DONE:    if (next_fetch) state_next = WAIT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        capture   = 1'b0;
        pc_load   = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        over_keep = 1'b0;
        if (IF_valid) begin
            case (state)
                IDLE: begin
                    cnt_load = 1'b1;
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        capture = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                DONE: begin
                    if (next_fetch) begin
                        pc_load  = 1'b1;
                        cnt_load = 1'b1;
                    end else begin
                        over_keep = 1'b1;
                    end
                end
                default: begin
                    capture = 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_ALIGN_CHK_EN
    logic misaligned;
    assign misaligned = (pc[1:0] != 2'b00);

    // A misaligned fetch is replaced by a NOP so decode never sees garbage
    always_comb begin
        inst_cap = misaligned ? 32'h0000_0000 : inst;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_err <= 1'b0;
        end else if (capture && misaligned) begin
            addr_err <= 1'b1;
        end
    end
`else
    always_comb begin
        inst_cap = inst;
    end

    assign addr_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            cnt     <= 2'd0;
            inst_r  <= 32'h0000_0000;
            IF_over <= 1'b0;
        end else begin
            IF_over <= capture | over_keep;
            if (!IF_valid) begin
                cnt <= 2'd0;
            end else if (cnt_load) begin
                cnt <= CNT_LOAD;
            end else if (cnt_dec) begin
                cnt <= cnt - 2'd1;
            end
            if (pc_load) begin
                pc <= jbr_bus[32] ? jbr_bus[31:0] : pc + 32'd4;
            end
            if (capture) begin
                inst_r <= inst_cap;
            end
        end
    end

    assign inst_addr = pc;
    assign IF_pc     = pc;
    assign IF_ID_bus = {pc, inst_r};

endmodule
